// File: rtl/arb_pkg.sv
// Shared types and helpers for the active-low round-robin arbiter family.
// Holds the controller state enum, the index-width helper and the hold-counter width.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int HOLD_CW = 16;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotate-priority selector: first set bit of req_mask at or after ptr, wrapping.
// Active-high mask in, valid plus index out; reusable by other arbiters.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = idx_w(N)
) (
    input  logic [N-1:0]    req_mask,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    // Scan N positions starting from ptr; the first hit wins.
    always_comb begin
        int  cand;
        logic hit;
        cand  = 0;
        hit   = 1'b0;
        valid = 1'b0;
        idx   = {IDXW{1'b0}};
        for (int i = 0; i < N; i++) begin
            cand  = (int'(ptr) + i) % N;
            hit   = !valid && req_mask[cand[IDXW-1:0]];
            idx   = hit ? cand[IDXW-1:0] : idx;
            valid = valid | hit;
        end
    end

endmodule

// File: rtl/arb_rr_lowreq.sv
// Round-robin arbiter with active-low requests/grants: grant, hold until release, one-cycle gap.
// Optional grant timeout with requester lockout is enabled by defining ARB_TIMEOUT_EN.
module arb_rr_lowreq
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 64
) (
    input  logic                C,
    input  logic                CLR_B,
    input  logic [N-1:0]        REQ_B,
    output logic [N-1:0]        GNT_B,
    output logic [idx_w(N)-1:0] GNT_IDX,
    output logic                BUSY_B,
    output logic                TOUT
);

    localparam int IDXW = idx_w(N);
    localparam logic [N-1:0] ALL_OFF = {N{1'b1}};

    if (N < 2 || N > 16 || HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_param_check
        $error("arb_rr_lowreq: N or HOLD_MAX outside legal range");
    end

    arb_state_t      state_r, state_s;
    logic [IDXW-1:0] ptr_r, ptr_s;
    logic [IDXW-1:0] idx_r, idx_s;
    logic [N-1:0]    gnt_b_r, gnt_b_s;
    logic            busy_b_r, busy_b_s;
    logic [N-1:0]    req_s;
    logic [N-1:0]    pick_mask_s;
    logic            pick_valid_s;
    logic [IDXW-1:0] pick_idx_s;
    logic            owner_req_s;
    logic [IDXW-1:0] ptr_next_s;

    function automatic logic [N-1:0] grant_vec(input logic [IDXW-1:0] i);
        return ~(N'(1'b1) << i);
    endfunction

    assign req_s       = ~REQ_B;
    assign owner_req_s = req_s[idx_r];
    assign ptr_next_s  = (idx_r == IDXW'(N - 1)) ? {IDXW{1'b0}} : idx_r + IDXW'(1);

`ifdef ARB_TIMEOUT_EN
    localparam logic [HOLD_CW-1:0] HOLD_LAST = HOLD_CW'(HOLD_MAX - 1);

    logic [HOLD_CW-1:0] cnt_r, cnt_s;
    logic [N-1:0]       lock_r, lock_s;
    logic               tout_r, tout_s;

    // Timed-out requesters stay out of the scan until they sample released.
    assign pick_mask_s = req_s & ~lock_r;
`else
    assign pick_mask_s = req_s;
`endif

    arb_rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req_mask (pick_mask_s),
        .ptr      (ptr_r),
        .valid    (pick_valid_s),
        .idx      (pick_idx_s)
    );

    // Next-state and next-output logic for the grant/hold/gap sequence.
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        idx_s    = idx_r;
        gnt_b_s  = gnt_b_r;
        busy_b_s = busy_b_r;
`ifdef ARB_TIMEOUT_EN
        cnt_s    = cnt_r;
        tout_s   = 1'b0;
        lock_s   = lock_r & req_s;
`endif
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s  = GRANT;
                    idx_s    = pick_idx_s;
                    gnt_b_s  = grant_vec(pick_idx_s);
                    busy_b_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    cnt_s    = {HOLD_CW{1'b0}};
`endif
                end else begin
                    gnt_b_s  = ALL_OFF;
                    busy_b_s = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req_s) begin
                    state_s  = GAP;
                    gnt_b_s  = ALL_OFF;
                    busy_b_s = 1'b1;
                    ptr_s    = ptr_next_s;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_r == HOLD_LAST) begin
                    state_s  = GAP;
                    gnt_b_s  = ALL_OFF;
                    busy_b_s = 1'b1;
                    ptr_s    = ptr_next_s;
                    tout_s   = 1'b1;
                    lock_s   = lock_s | ~grant_vec(idx_r);
                end
`endif
                else begin
                    busy_b_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    cnt_s    = cnt_r + HOLD_CW'(1);
`endif
                end
            end
            GAP: begin
                state_s  = IDLE;
                gnt_b_s  = ALL_OFF;
                busy_b_s = 1'b1;
            end
            default: begin
                state_s  = IDLE;
                gnt_b_s  = ALL_OFF;
                busy_b_s = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge C or negedge CLR_B) begin
        if (!CLR_B) begin
            state_r  <= IDLE;
            ptr_r    <= {IDXW{1'b0}};
            idx_r    <= {IDXW{1'b0}};
            gnt_b_r  <= ALL_OFF;
            busy_b_r <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_r    <= {HOLD_CW{1'b0}};
            lock_r   <= {N{1'b0}};
            tout_r   <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            idx_r    <= idx_s;
            gnt_b_r  <= gnt_b_s;
            busy_b_r <= busy_b_s;
`ifdef ARB_TIMEOUT_EN
            cnt_r    <= cnt_s;
            lock_r   <= lock_s;
            tout_r   <= tout_s;
`endif
        end
    end

    assign GNT_B   = gnt_b_r;
    assign GNT_IDX = idx_r;
    assign BUSY_B  = busy_b_r;
`ifdef ARB_TIMEOUT_EN
    assign TOUT    = tout_r;
`else
    assign TOUT    = 1'b0;
`endif

endmodule

// File: tb/tb_arb_rr_lowreq.sv
// Self-checking bench for arb_rr_lowreq: vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the arbitration rules.
module tb_arb_rr_lowreq;

    localparam int N    = 4;
    localparam int IDXW = 2;
`ifdef ARB_TIMEOUT_EN
    localparam int  HOLD_MAX = 4;
    localparam bit  TIMEOUT  = 1'b1;
`else
    localparam int  HOLD_MAX = 64;
    localparam bit  TIMEOUT  = 1'b0;
`endif

    logic            C = 1'b0;
    logic            CLR_B;
    logic [N-1:0]    REQ_B;
    logic [N-1:0]    GNT_B;
    logic [IDXW-1:0] GNT_IDX;
    logic            BUSY_B;
    logic            TOUT;

    arb_rr_lowreq #(
        .N        (N),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .C       (C),
        .CLR_B   (CLR_B),
        .REQ_B   (REQ_B),
        .GNT_B   (GNT_B),
        .GNT_IDX (GNT_IDX),
        .BUSY_B  (BUSY_B),
        .TOUT    (TOUT)
    );

    always #5 C = ~C;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: who owns the resource, whether a gap is pending, rotation pointer.
    int           m_owner;
    bit           m_gap;
    int           m_ptr;
    int           m_last;
    int           m_held;
    bit [N-1:0]   m_lock;
    bit           m_tout;

    typedef struct {
        logic [N-1:0]    req_b;
        logic [N-1:0]    gnt_b;
        logic [IDXW-1:0] idx;
        logic            busy_b;
    } vec_t;

    vec_t tbl [0:16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_gap   = 1'b0;
        m_ptr   = 0;
        m_last  = 0;
        m_held  = 0;
        m_lock  = '0;
        m_tout  = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] rb);
        bit found;
        m_tout = 1'b0;
        for (int i = 0; i < N; i++) if (rb[i]) m_lock[i] = 1'b0;
        if (m_owner >= 0) begin
            if (rb[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (TIMEOUT && m_held == HOLD_MAX) begin
                m_lock[m_owner] = 1'b1;
                m_tout  = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!found && !rb[j] && !m_lock[j]) begin
                    found   = 1'b1;
                    m_owner = j;
                    m_last  = j;
                    m_held  = 1;
                end
            end
        end
    endtask

    // Drive one cycle of requests, advance the model, sample #1 after the edge.
    task automatic step(input logic [N-1:0] rb);
        logic [N-1:0] e_gnt;
        REQ_B = rb;
        model_edge(rb);
        @(posedge C);
        #1;
        e_gnt = {N{1'b1}};
        if (m_owner >= 0) e_gnt[m_owner] = 1'b0;
        chk("model_gnt_b", 32'(GNT_B), 32'(e_gnt));
        chk("model_gnt_idx", 32'(GNT_IDX), 32'(m_last));
        chk("model_busy_b", 32'(BUSY_B), 32'(m_owner < 0));
        chk("model_tout", 32'(TOUT), 32'(m_tout));
    endtask

    initial begin
        int low_cnt;
        int tout_cnt;
        logic [N-1:0] rb;

        // Round robin: hold two cycles, owner releases one cycle, gap, next owner.
        tbl[0]  = '{4'b0000, 4'b1110, 2'd0, 1'b0};
        tbl[1]  = '{4'b0000, 4'b1110, 2'd0, 1'b0};
        tbl[2]  = '{4'b0001, 4'b1111, 2'd0, 1'b1};
        tbl[3]  = '{4'b0000, 4'b1111, 2'd0, 1'b1};
        tbl[4]  = '{4'b0000, 4'b1101, 2'd1, 1'b0};
        tbl[5]  = '{4'b0000, 4'b1101, 2'd1, 1'b0};
        tbl[6]  = '{4'b0010, 4'b1111, 2'd1, 1'b1};
        tbl[7]  = '{4'b0000, 4'b1111, 2'd1, 1'b1};
        tbl[8]  = '{4'b0000, 4'b1011, 2'd2, 1'b0};
        tbl[9]  = '{4'b0000, 4'b1011, 2'd2, 1'b0};
        tbl[10] = '{4'b0100, 4'b1111, 2'd2, 1'b1};
        tbl[11] = '{4'b0000, 4'b1111, 2'd2, 1'b1};
        tbl[12] = '{4'b0000, 4'b0111, 2'd3, 1'b0};
        tbl[13] = '{4'b0000, 4'b0111, 2'd3, 1'b0};
        tbl[14] = '{4'b1000, 4'b1111, 2'd3, 1'b1};
        tbl[15] = '{4'b0000, 4'b1111, 2'd3, 1'b1};
        tbl[16] = '{4'b0000, 4'b1110, 2'd0, 1'b0};

        CLR_B = 1'b0;
        REQ_B = 4'b0000;
        model_reset();
        #23;
        chk("reset_gnt_b", 32'(GNT_B), 32'h0000_000f);
        chk("reset_busy_b", 32'(BUSY_B), 32'd1);
        chk("reset_gnt_idx", 32'(GNT_IDX), 32'd0);
        chk("reset_tout", 32'(TOUT), 32'd0);
        @(posedge C);
        #4;
        CLR_B = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].req_b);
            chk("tbl_gnt_b", 32'(GNT_B), 32'(tbl[i].gnt_b));
            chk("tbl_gnt_idx", 32'(GNT_IDX), 32'(tbl[i].idx));
            chk("tbl_busy_b", 32'(BUSY_B), 32'(tbl[i].busy_b));
        end
        step(4'b1111);
        step(4'b1111);

        // Withdrawn request: bit 2 pulses low during owner 1's grant and is never served.
        step(4'b1101);
        chk("wd_grant1", 32'(GNT_B), 32'h0000_000d);
        step(4'b1001);
        chk("wd_no_glitch", 32'(GNT_B[2]), 32'd1);
        step(4'b1101);
        chk("wd_still_owner", 32'(GNT_B), 32'h0000_000d);
        step(4'b1111);
        step(4'b1111);
        step(4'b1111);
        chk("wd_never_granted", 32'(GNT_B), 32'h0000_000f);
        chk("wd_idx_held", 32'(GNT_IDX), 32'd1);

        // Pointer wrap: after owner 2 releases, bits 0 and 3 contend and 3 wins.
        step(4'b1011);
        step(4'b1111);
        step(4'b1111);
        step(4'b0110);
        chk("wrap_grant3", 32'(GNT_IDX), 32'd3);
        chk("wrap_gnt_b3", 32'(GNT_B), 32'h0000_0007);
        step(4'b1110);
        step(4'b1110);
        step(4'b1110);
        chk("wrap_then0", 32'(GNT_B), 32'h0000_000e);
        step(4'b1111);
        step(4'b1111);

        // Reset mid-grant removes the grant before the next clock edge.
        step(4'b1110);
        chk("rst_pre_grant", 32'(GNT_B), 32'h0000_000e);
        #3;
        CLR_B = 1'b0;
        model_reset();
        #1;
        chk("rst_async_gnt_b", 32'(GNT_B), 32'h0000_000f);
        chk("rst_async_busy_b", 32'(BUSY_B), 32'd1);
        #2;
        CLR_B = 1'b1;
        step(4'b1110);
        chk("rst_regrant0", 32'(GNT_B), 32'h0000_000e);
        step(4'b1111);
        step(4'b1111);

        // Long hold of requester 1: revoked by timeout when enabled, otherwise held.
        low_cnt  = 0;
        tout_cnt = 0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 12; i++) begin
            step(4'b1101);
            if (GNT_B[1] == 1'b0) low_cnt++;
            if (TOUT == 1'b1) tout_cnt++;
        end
        chk("to_hold_cycles", 32'(low_cnt), 32'd4);
        chk("to_pulses", 32'(tout_cnt), 32'd1);
        step(4'b1001);
        chk("to_other_granted", 32'(GNT_B), 32'h0000_000b);
        step(4'b1111);
        step(4'b1111);
        step(4'b1101);
        chk("to_unlocked_regrant", 32'(GNT_B), 32'h0000_000d);
`else
        for (int i = 0; i < 120; i++) begin
            step(4'b1101);
            if (GNT_B[1] == 1'b0) low_cnt++;
            if (TOUT == 1'b1) tout_cnt++;
        end
        chk("nto_hold_cycles", 32'(low_cnt), 32'd120);
        chk("nto_no_tout", 32'(tout_cnt), 32'd0);
`endif
        step(4'b1111);
        step(4'b1111);

        // Random traffic: bits toggle occasionally so owners hold for a while; rare resets.
        rb = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) rb[b] = ~rb[b];
            end
            step(rb);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                CLR_B = 1'b0;
                model_reset();
                #1;
                chk("rand_rst_gnt_b", 32'(GNT_B), 32'h0000_000f);
                #1;
                CLR_B = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_rr_lowreq.md
Name: arb_rr_lowreq

Overview:
- Clocked round-robin arbiter that shares one resource among N requesters.
- Requests and grants are active-low, matching the library's inverted-input gate convention.
- It sequences ownership: grant, hold until release, then a one-cycle turnaround before the next grant.
- It sits in front of any shared bus or port whose request lines are wired active-low.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- HOLD_MAX, 64, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- C  input  1  clock; all state updates on the rising edge.
- CLR_B  input  1  asynchronous active-low reset.
- REQ_B  input  N  request per requester, low = requesting; synchronous to C.
- GNT_B  output  N  grant per requester, low = granted; at most one bit low; registered.
- GNT_IDX  output  IDXW  index of the current or last grant; IDXW = max(1, clog2(N)); registered.
- BUSY_B  output  1  low while any grant is active; registered; equals the AND-reduce of GNT_B.
- TOUT  output  1  one-cycle high pulse when a grant is revoked by timeout; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Interface: one clock (C); reset CLR_B is asynchronous and active-low.
- CLR_B low, taking effect immediately (no clock needed):
  - GNT_B = all 1s, BUSY_B = 1, GNT_IDX = 0, TOUT = 0.
  - State = IDLE, priority pointer PTR = 0, hold counter = 0.
- Reset mid-grant drops the grant asynchronously; the requester must tolerate this.
- States: IDLE, GRANT, GAP.
- IDLE:
  - On an edge where any REQ_B bit is low, select the first low bit scanning PTR, PTR+1, ... wrapping modulo N.
  - On that same edge: drive its GNT_B bit low, set GNT_IDX, drive BUSY_B low, go to GRANT.
  - Latency: REQ_B low sampled at edge k gives GNT_B low after edge k.
- GRANT:
  - Hold the grant while the owner's REQ_B samples low.
  - Other requests are ignored; no preemption.
  - When the owner's REQ_B samples high at edge m: GNT_B all 1s and BUSY_B high after edge m; PTR = (owner+1) mod N; go to GAP.
- GAP:
  - One dead cycle with no grant, then IDLE unconditionally.
  - Earliest next grant is after edge m+2, giving a guaranteed bus turnaround.
- A request withdrawn before it is sampled is never granted; requests are not latched.
- Simultaneous requests are resolved by PTR rotation only; index order is irrelevant except relative to PTR.
- PTR wraps from N-1 to 0.
- With a single persistent requester, it is regranted every third cycle pair (grant, release, gap) with no starvation.
- GNT_IDX holds its last value when idle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit hold counter clears on grant and increments each GRANT cycle.
  - If the counter reaches HOLD_MAX while the owner's REQ_B is still low: revoke the grant (GNT_B all 1s next edge), pulse TOUT high for exactly one cycle, advance PTR, go to GAP.
  - The revoked requester is locked out until its REQ_B samples high at least once. The lockout bit is cleared by that sample and by reset. Locked requesters are masked from selection.
  - Normal release on the same edge as the timeout counts as a release: no TOUT.
- Undefined: no counter, no lockout logic; TOUT is constant 0; grants may be held indefinitely.

Decomposition:
- Package arb_pkg holds:
  - the state enum (IDLE, GRANT, GAP);
  - the IDXW width function;
  - the counter width constant HOLD_CW = 16.
- One natural sub-module, arb_rr_pick: purely combinational rotate-priority select.
  - Inputs: active-high request mask, PTR.
  - Outputs: valid, index.
  - Reusable by other arbiters in the library.

Test Plan:
- Reset mid-grant: N=4, REQ_B=1110, grant on bit 0; assert CLR_B low between edges -> GNT_B=1111 and BUSY_B=1 immediately, before the next edge; after release, REQ_B=1110 -> grant again on bit 0 after the first edge.
- Round-robin: REQ_B=0000 held, each owner releases for one cycle after a 2-cycle hold -> grant order 0,1,2,3,0; GAP cycle with GNT_B=1111 between each grant.
- Withdrawn request: REQ_B[2] low for one cycle during another's GRANT, then high -> never granted; no glitch on GNT_B[2].
- Wrap and pointer: PTR=3 after grant to 2, REQ_B=0110 (bits 0 and 3 low) -> grant 3; next grant 0.
- Timeout (macro defined, HOLD_MAX=4): REQ_B[1] held low -> GNT_B[1] low for exactly 4 cycles, TOUT=1 for one cycle; bit 1 not regranted until REQ_B[1] goes high and low again; REQ_B[2] low is granted after GAP.
- Macro undefined, same stimulus -> grant held for 100+ cycles, TOUT constant 0.
